// File: rtl/loba_pkg.sv
// Shared defaults and FSM state type for the LOBA product accumulator.
package loba_pkg;

  localparam int PW_DEF      = 32;
  localparam int AW_DEF      = 40;
  localparam int CW_DEF      = 16;
  localparam int MAX_LEN_DEF = 256;

  typedef enum logic [0:0] {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

endpackage

// File: rtl/loba_sat_add.sv
// Saturating adder: zero-extends a PW-bit product onto an AW-bit sum and
// clamps to all-ones when the addition carries out of AW bits.
module loba_sat_add
  import loba_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [AW-1:0] y,
  output logic          ovf
);

  logic [AW:0] raw_s;

  // Wide add with one spare bit; the spare bit is the carry-out.
  always_comb begin
    raw_s = {1'b0, a} + {{(AW + 1 - PW){1'b0}}, b};
    if (raw_s[AW]) begin
      y   = {AW{1'b1}};
      ovf = 1'b1;
    end else begin
      y   = raw_s[AW-1:0];
      ovf = 1'b0;
    end
  end

endmodule

// File: rtl/loba_acc.sv
// Group accumulator for LOBA multiplier products: sums products with
// saturation until in_last or MAX_LEN beats, then holds the result until
// the consumer takes it.
module loba_acc
  import loba_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int AW      = AW_DEF,
  parameter int CW      = CW_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_p,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_cnt,
  output logic          out_sat
);

  state_t        state_r;
  logic [AW-1:0] acc_r;
  logic [CW-1:0] cnt_r;
  logic          sat_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic [AW-1:0] sum_s;
  logic          ovf_s;
  logic [CW-1:0] cnt_nxt_s;
  logic          accept_s;
  logic          close_s;

  loba_sat_add #(.PW(PW), .AW(AW)) u_sat_add (
    .a   (acc_r),
    .b   (in_p),
    .y   (sum_s),
    .ovf (ovf_s)
  );

  // Next count and group-close decision for the beat offered this cycle.
  always_comb begin
    cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    accept_s  = in_valid && in_ready_r;
    close_s   = in_last || (cnt_nxt_s == CW'(MAX_LEN));
  end

  // Two-state FSM owning the accumulator, count, sticky flag and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ACC;
      acc_r       <= {AW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      sat_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ACC: begin
          if (accept_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_nxt_s;
            sat_r <= sat_r | ovf_s;
            if (close_s) begin
              state_r     <= OUT;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= ACC;
            end
          end else begin
            state_r <= ACC;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_r     <= ACC;
            acc_r       <= {AW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            sat_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= OUT;
          end
        end
        default: begin
          state_r     <= ACC;
          acc_r       <= {AW{1'b0}};
          cnt_r       <= {CW{1'b0}};
          sat_r       <= 1'b0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = acc_r;
  assign out_cnt   = cnt_r;
  assign out_sat   = sat_r;

endmodule

// File: tb/tb_loba_acc.sv
// Scoreboard bench for loba_acc: instance 0 uses default parameters,
// instance 1 uses a narrow accumulator and MAX_LEN=4 to reach saturation
// and forced closes quickly.
module tb_loba_acc;

  typedef struct packed {
    logic [39:0] sum;
    logic [15:0] cnt;
    logic        sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]       in_valid;
  logic [1:0]       in_last;
  logic [1:0][31:0] in_p;
  logic [1:0]       out_ready;
  wire  [1:0]       in_ready;
  wire  [1:0]       out_valid;
  wire  [1:0]       out_sat;
  wire  [1:0][15:0] out_cnt;
  wire  [1:0][39:0] out_sum;

  int total = 0;
  int bad   = 0;
  int rmode [2] = '{1, 1};   // 0: out_ready low, 1: high, 2: random
  longint unsigned grp_tot [2] = '{64'd0, 64'd0};
  int grp_n [2] = '{0, 0};
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  loba_acc u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_p(in_p[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(out_sum[0]), .out_cnt(out_cnt[0]), .out_sat(out_sat[0])
  );

  loba_acc #(.PW(32), .AW(33), .CW(16), .MAX_LEN(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_p(in_p[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(out_sum[1][32:0]), .out_cnt(out_cnt[1]), .out_sat(out_sat[1])
  );
  assign out_sum[1][39:33] = 7'd0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a group's result is min(true sum, 2^AW-1); flagged when it exceeded.
  function automatic void model_beat(int d, logic [31:0] p, logic last);
    longint unsigned mx;
    exp_t e;
    int ml;
    mx = (64'd1 << ((d == 0) ? 40 : 33)) - 64'd1;
    ml = (d == 0) ? 256 : 4;
    grp_tot[d] += longint'(p);
    grp_n[d]++;
    if (last || grp_n[d] == ml) begin
      e.sum = (grp_tot[d] > mx) ? mx[39:0] : grp_tot[d][39:0];
      e.cnt = grp_n[d][15:0];
      e.sat = (grp_tot[d] > mx);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      grp_tot[d] = 64'd0;
      grp_n[d]   = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer one beat; must be called at posedge+1. Returns at posedge+1 after acceptance.
  task automatic send(int d, logic [31:0] p, logic last);
    logic rdy;
    int   waitc = 0;
    bit   done  = 1'b0;
    in_valid[d] = 1'b1;
    in_p[d]     = p;
    in_last[d]  = last;
    while (!done) begin
      @(negedge clk);
      rdy = in_ready[d];
      @(posedge clk); #1;
      if (rdy) begin
        model_beat(d, p, last);
        done = 1'b1;
      end else if (++waitc > 200) begin
        chk("send timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic rand_run(int d, int n);
    logic [31:0] p;
    logic        last;
    int          sel;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      sel = $urandom_range(0, 7);
      if (sel == 0)      p = 32'd0;
      else if (sel < 4)  p = 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
      else               p = $urandom;
      last = (d == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 5) == 0);
      send(d, p, last);
    end
  endtask

  // Consumer-side ready pattern, applied just after each rising edge.
  always @(posedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      if (rmode[d] == 0)      out_ready[d] = 1'b0;
      else if (rmode[d] == 1) out_ready[d] = 1'b1;
      else                    out_ready[d] = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: every handshake pops the oldest expected result and compares it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            chk("unexpected result", 64'(out_sum[d]), 64'hDEAD);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("result sum", 64'(out_sum[d]), 64'(e.sum));
            chk("result cnt", 64'(out_cnt[d]), 64'(e.cnt));
            chk("result sat", 64'(out_sat[d]), 64'(e.sat));
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitc;
    rst = 1'b1;
    in_valid = 2'b00;
    in_last  = 2'b00;
    in_p     = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset in_ready", 64'(in_ready[d]), 64'd1);
      chk("reset out_valid", 64'(out_valid[d]), 64'd0);
      chk("reset out_sum", 64'(out_sum[d]), 64'd0);
      chk("reset out_cnt", 64'(out_cnt[d]), 64'd0);
      chk("reset out_sat", 64'(out_sat[d]), 64'd0);
    end
    step();

    // Basic group of three with one-cycle result latency.
    send(0, 32'd100, 1'b0);
    send(0, 32'd200, 1'b0);
    send(0, 32'd300, 1'b1);
    @(negedge clk);
    chk("basic out_valid", 64'(out_valid[0]), 64'd1);
    chk("basic out_sum", 64'(out_sum[0]), 64'd600);
    chk("basic out_cnt", 64'(out_cnt[0]), 64'd3);
    chk("basic out_sat", 64'(out_sat[0]), 64'd0);
    step();
    step();

    // Saturation on the narrow instance: three max products exceed 2^33-1.
    send(1, 32'hFFFF_FFFF, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    chk("sat out_sum", 64'(out_sum[1]), 64'h1_FFFF_FFFF);
    chk("sat out_sat", 64'(out_sat[1]), 64'd1);
    step();
    step();

    // Forced close at MAX_LEN=4, then a short group closed by in_last.
    for (int i = 1; i <= 6; i++) begin
      send(1, 32'd1, (i == 6));
      if (i == 4) begin
        @(negedge clk);
        chk("maxlen out_valid", 64'(out_valid[1]), 64'd1);
        chk("maxlen out_cnt", 64'(out_cnt[1]), 64'd4);
        step();
      end
    end
    @(negedge clk);
    chk("maxlen tail cnt", 64'(out_cnt[1]), 64'd2);
    chk("maxlen tail sum", 64'(out_sum[1]), 64'd2);
    step();
    step();

    // Back-pressure: result held stable, input ignored while stalled.
    rmode[0] = 0;
    step();
    send(0, 32'd7, 1'b0);
    send(0, 32'd8, 1'b0);
    send(0, 32'd9, 1'b1);
    in_valid[0] = 1'b1;
    in_p[0]     = 32'd999;
    in_last[0]  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall out_valid", 64'(out_valid[0]), 64'd1);
      chk("stall in_ready", 64'(in_ready[0]), 64'd0);
      chk("stall out_sum", 64'(out_sum[0]), 64'd24);
      chk("stall out_cnt", 64'(out_cnt[0]), 64'd3);
      step();
    end
    in_valid[0] = 1'b0;
    in_last[0]  = 1'b0;
    rmode[0]    = 1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("release out_valid", 64'(out_valid[0]), 64'd0);
    chk("release out_sum", 64'(out_sum[0]), 64'd0);
    chk("release out_cnt", 64'(out_cnt[0]), 64'd0);
    chk("release in_ready", 64'(in_ready[0]), 64'd1);
    step();

    // Reset in the middle of a group discards the partial sum.
    send(0, 32'd5, 1'b0);
    send(0, 32'd7, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      grp_tot[d] = 64'd0;
      grp_n[d]   = 0;
    end
    @(negedge clk);
    chk("midrst out_sum", 64'(out_sum[0]), 64'd0);
    chk("midrst out_cnt", 64'(out_cnt[0]), 64'd0);
    step();
    send(0, 32'd9, 1'b1);
    @(negedge clk);
    chk("postrst out_sum", 64'(out_sum[0]), 64'd9);
    chk("postrst out_cnt", 64'(out_cnt[0]), 64'd1);
    step();

    // Random traffic on both instances with random consumer stalls.
    rmode[0] = 2;
    rmode[1] = 2;
    fork
      rand_run(0, 6000);
      rand_run(1, 4000);
    join
    rmode[0] = 1;
    rmode[1] = 1;
    waitc = 0;
    while ((q0.size() != 0 || q1.size() != 0) && waitc < 50) begin
      step();
      waitc++;
    end
    chk("drain q0", 64'(q0.size()), 64'd0);
    chk("drain q1", 64'(q1.size()), 64'd0);
    chk("open group d0", 64'(grp_n[0]), 64'(out_cnt[0]));
    chk("open group d1", 64'(grp_n[1]), 64'(out_cnt[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/loba_acc.md
LOBA_ACC -- requirements
Module: loba_acc

Interface
REQ-001 The block SHALL have parameter PW, default 32, the product width; it matches the 32-bit output of the 16x16 LOBA multiplier.
REQ-002 The block SHALL have parameter AW, default 40, the accumulator width; AW >= PW+1.
REQ-003 The block SHALL have parameter CW, default 16, the group-count width.
REQ-004 The block SHALL have parameter MAX_LEN, default 256, the forced group-close length; 1 <= MAX_LEN <= 2^CW-1.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1, meaning the upstream product is valid.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block accepts in_p this cycle.
REQ-009 The block SHALL have port in_p, input, PW, an unsigned product from the LOBA multiplier.
REQ-010 The block SHALL have port in_last, input, 1, marking the final product of a group.
REQ-011 The block SHALL have port out_valid, output, 1, meaning the group result is valid.
REQ-012 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-013 The block SHALL have port out_sum, output, AW, the saturated sum of the group's products.
REQ-014 The block SHALL have port out_cnt, output, CW, the number of products in the group.
REQ-015 The block SHALL have port out_sat, output, 1, a sticky flag set when saturation occurred in the group.

Function
REQ-016 The FSM SHALL have exactly two states: ACC and OUT; reset state ACC.
REQ-017 A beat SHALL be accepted when in_valid && in_ready; in_ready = (state==ACC).
REQ-018 On an accepted beat: acc <= sat_add(acc, in_p); cnt <= cnt+1; sat <= sat | overflow.
REQ-019 sat_add SHALL zero-extend in_p to AW and clamp the result to 2^AW-1 on carry-out; overflow = carry-out.
REQ-020 The group SHALL close on an accepted beat with in_last=1, or when the accepted beat makes cnt == MAX_LEN; ACC -> OUT at the next edge.
REQ-021 Latency: closing beat accepted at edge n -> out_valid=1 from edge n+1, with out_sum/out_cnt/out_sat including that beat.
REQ-022 In OUT: out_valid=1 and in_ready=0; out_sum, out_cnt, and out_sat SHALL stay stable until out_ready=1.
REQ-023 On out_valid && out_ready: OUT -> ACC; acc, cnt, and sat SHALL clear to 0 at the same edge; first beat of the next group acceptable the following cycle.
REQ-024 In ACC: out_valid=0; out_sum, out_cnt, and out_sat SHALL show the running acc, cnt, and sat (don't-care to the consumer).
REQ-025 in_valid=0 in ACC SHALL leave all state unchanged; gaps between beats are allowed.
REQ-026 in_last asserted simultaneously with cnt reaching MAX_LEN SHALL close a single group (no empty group).
REQ-027 in_p=0 beats SHALL count toward cnt and MAX_LEN.
REQ-028 in_valid, in_p, and in_last are ignored while in_ready=0; upstream holds them per valid/ready rules.

Reset
REQ-029 rst=1 at an edge SHALL force state=ACC, acc=0, cnt=0, sat=0, out_valid=0, and in_ready=1 at the next cycle, regardless of state.
REQ-030 Reset mid-group or in OUT SHALL discard the partial or pending result without emitting it.
REQ-031 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-032 Package loba_pkg SHALL hold PW, AW, CW, MAX_LEN defaults and the state enum {ACC, OUT}.
REQ-033 Sub-module loba_sat_add (combinational, AW-bit saturating add with overflow output) SHALL implement REQ-019.
REQ-034 The top-level loba_acc SHALL contain the FSM, the acc/cnt/sat registers, and the handshake logic only.

Verification
REQ-035 Products 100, 200, 300 with in_last on the third, out_ready=1 -> out_valid one cycle later, out_sum=600, out_cnt=3, out_sat=0.
REQ-036 acc preset near full: 2^40-2^32 plus two beats of 0xFFFFFFFF -> out_sum=2^40-1, out_sat=1.
REQ-037 MAX_LEN=4, six beats of 1 with no in_last, out_ready=1 -> first result sum=4, cnt=4; then sum=2, cnt=2 after in_last on beat 6.
REQ-038 out_ready held 0 for 5 cycles in OUT -> in_ready=0, outputs stable; release -> one handshake, then acc=0.
REQ-039 rst pulsed after two beats (5, 7), then a single beat of 9 with in_last -> out_sum=9, out_cnt=1.
REQ-040 Random valid/ready gaps versus a reference model over 10k beats -> sums, counts, and sat flags match exactly.
